// File: rtl/regfile_scan_pkg.sv
// Shared types and helpers for the register-file scan master.
// Frame layout, LSB first: op, addr, turnaround, data.
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

package regfile_scan_pkg;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   function automatic int frame_len(input int addr_w, input int width);
      return addr_w + width + 32'sd2;
   endfunction

endpackage

// File: rtl/scan_phase_gen.sv
// Shift-clock timing for one scan frame: HALF-cycle phases, sClock level and bit index.
// The pulses are combinational and describe the clk edge about to happen.
module scan_phase_gen #(
   parameter int HALF  = 2,
   parameter int NBITS = 38
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic active,
   input  logic kill,
   output logic sclk,
   output logic low_start,
   output logic high_end,
   output logic last_bit
);

   localparam int BW = $clog2(NBITS + 1);

   logic [7:0]    phase_r;
   logic          level_r;
   logic [BW-1:0] bit_r;
   logic          phase_end_s;
   logic          last_idx_s;

   // Decode the edge type from the current phase, level and bit index.
   always_comb begin
      phase_end_s = active && (phase_r == 8'(HALF - 1));
      last_idx_s  = (bit_r == BW'(NBITS - 1));
      high_end    = phase_end_s && level_r;
      last_bit    = high_end && last_idx_s;
      low_start   = high_end && !last_idx_s;
   end

   // Phase/bit counters; they restart at acceptance and never count past the frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase_r <= 8'd0;
         level_r <= 1'b0;
         bit_r   <= '0;
      end else if (start) begin
         phase_r <= 8'd0;
         level_r <= 1'b0;
         bit_r   <= '0;
      end else if (!active || kill) begin
         phase_r <= 8'd0;
         level_r <= 1'b0;
         bit_r   <= '0;
      end else if (phase_end_s) begin
         phase_r <= 8'd0;
         level_r <= ~level_r;
         if (level_r) begin
            bit_r <= last_idx_s ? '0 : bit_r + BW'(1);
         end else begin
            bit_r <= bit_r;
         end
      end else begin
         phase_r <= phase_r + 8'd1;
         level_r <= level_r;
         bit_r   <= bit_r;
      end
   end

   assign sclk = level_r;

endmodule

// File: rtl/regfile_scan_master.sv
// Initiator end of the register-file shift interface: serializes one read or
// write frame per request and deserializes read data back into rData.
module regfile_scan_master
   import regfile_scan_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int WIDTH  = `WORD_LENGTH,
   parameter int HALF   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              op,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WIDTH-1:0]  wData,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic [WIDTH-1:0]  rData,
   output logic              sClock,
   output logic              sEnable,
   output logic              sIn,
   input  logic              sOut
);

   localparam int N = frame_len(ADDR_W, WIDTH);

   state_t           state_r;
   state_t           state_nxt_s;
   logic             accept_s;
   logic             finish_s;
   logic             low_start_s;
   logic             high_end_s;
   logic             last_bit_s;
   logic             op_r;
   logic [N-1:0]     frame_r;
   logic [N-1:0]     frame_init_s;
   logic [WIDTH-1:0] cap_r;
   logic [WIDTH-1:0] cap_nxt_s;

   scan_phase_gen #(
      .HALF  (HALF),
      .NBITS (N)
   ) u_phase (
      .clk       (clk),
      .rst       (rst),
      .start     (accept_s),
      .active    (state_r == SHIFT),
      .kill      (abort),
      .sclk      (sClock),
      .low_start (low_start_s),
      .high_end  (high_end_s),
      .last_bit  (last_bit_s)
   );

   // Abort beats both a new request and a normal finish on the same edge.
   always_comb begin
      accept_s     = (state_r == IDLE) && req && !abort;
      finish_s     = last_bit_s && !abort;
      cap_nxt_s    = {sOut, cap_r[WIDTH-1:1]};
      frame_init_s = {((op == OP_WRITE) ? wData : {WIDTH{1'b0}}), 1'b0, addr, op};
      state_nxt_s  = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               state_nxt_s = SHIFT;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SHIFT: begin
            if (abort || finish_s) begin
               state_nxt_s = IDLE;
            end else begin
               state_nxt_s = SHIFT;
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Frame shifter and serial-side outputs; sIn only moves at a low-phase start.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy    <= 1'b0;
         sEnable <= 1'b0;
         sIn     <= 1'b0;
         op_r    <= OP_READ;
         frame_r <= '0;
      end else if (accept_s) begin
         busy    <= 1'b1;
         sEnable <= 1'b1;
         sIn     <= frame_init_s[0];
         op_r    <= op;
         frame_r <= frame_init_s;
      end else if ((state_r == SHIFT) && (abort || finish_s)) begin
         busy    <= 1'b0;
         sEnable <= 1'b0;
         sIn     <= 1'b0;
         op_r    <= op_r;
         frame_r <= '0;
      end else if (low_start_s) begin
         busy    <= busy;
         sEnable <= sEnable;
         sIn     <= frame_r[1];
         op_r    <= op_r;
         frame_r <= {1'b0, frame_r[N-1:1]};
      end else begin
         busy    <= busy;
         sEnable <= sEnable;
         sIn     <= sIn;
         op_r    <= op_r;
         frame_r <= frame_r;
      end
   end

   // Capture every sample; after the last bit only the data field remains.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cap_r <= '0;
      end else if (high_end_s) begin
         cap_r <= cap_nxt_s;
      end else begin
         cap_r <= cap_r;
      end
   end

   // Completion pulse and read-data update.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done  <= 1'b0;
         rData <= '0;
      end else begin
         done <= finish_s;
         if (finish_s && (op_r == OP_READ)) begin
            rData <= cap_nxt_s;
         end else begin
            rData <= rData;
         end
      end
   end

endmodule
